lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit controller sitting between the pipeline's memory stage and the word-only data memory port. Accepts one byte/halfword/word load or store per request. Performs address alignment, sub-word lane extraction with sign/zero extension, and read-modify-write for SB/SH, since the data memory only writes full 32-bit words. Drives the memory's address/data/write-enable through registers, and stalls the pipeline until each access completes.

## Interface

Parameters: none.

- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  pipeline presents an access; held stable while stall=1
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  32  byte address
- req_wdata  input  32  store data, low bits used for SB/SH
- stall  output  1  pipeline must hold current request
- resp_valid  output  1  load data valid this cycle
- resp_rdata  output  32  extended load data; 0 when resp_valid=0
- misaligned  output  1  one-cycle fault pulse: misaligned or illegal access
- mem_addr  output  32  registered word address {addr[31:2],2'b00}
- mem_din  output  32  registered write data
- mem_we  output  1  registered write enable
- mem_dout  input  32  memory read data, combinational from mem_addr

## Operation

- States: IDLE, LOAD, RMW_RD, WRITE, FAULT. Request sampled only in IDLE.
- Legal: loads 000/001/010/100/101; stores 000/001/010. Halfword needs addr[0]=0; word needs addr[1:0]=00. Anything else is a fault.
- IDLE, req_valid=0: stall=0. Stay IDLE.
- IDLE, legal load: stall=1. Register mem_addr, we=0, funct3, addr[1:0]. Go to LOAD.
- IDLE, SW: stall=1. Register mem_addr, mem_din=req_wdata, mem_we=1. Go to WRITE.
- IDLE, SB/SH: stall=1. Register mem_addr, we=0, wdata, funct3, offset. Go to RMW_RD.
- IDLE, fault: stall=1. No memory register change. Go to FAULT.
- LOAD: stall=0, resp_valid=1. Go to IDLE.
  - Byte lane = offset; half lane = offset[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- RMW_RD: stall=1.
  - Merge mem_dout with stored data: SB replaces byte lane offset with wdata[7:0]; SH replaces half lane offset[1] with wdata[15:0].
  - Register the result into mem_din, set mem_we=1. Go to WRITE.
- WRITE: stall=0; memory commits mem_din at the edge ending this cycle. Clear mem_we. Go to IDLE.
- FAULT: stall=0, misaligned=1, resp_valid=0. Go to IDLE.
- mem_we is 1 only in WRITE.

## Timing

- Reset values: state IDLE, mem_addr=0, mem_din=0, mem_we=0, stall=0, resp_valid=0, resp_rdata=0, misaligned=0.
- stall, resp_valid, resp_rdata and misaligned are combinational from state and the request.
- Latency counted from the accept cycle (IDLE with req_valid=1):
  - Load / SW / fault: 2 cycles, stall high 1 cycle.
  - SB/SH: 3 cycles, stall high 2 cycles.
  - Back-to-back requests: next request is accepted in the cycle after the completion cycle.
- Reset asserted mid-access: mem_we drops to 0 immediately, no write occurs, a partial RMW is abandoned with memory unchanged, and state returns to IDLE.
- req_* changes while in a non-IDLE state are ignored.
- Offset 3 byte lane and half lane 1 use bits [31:24] and [31:16] respectively.

## Test plan

- Reset: assert rst mid-idle -> mem_we=0, mem_addr=0, stall=0, resp_valid=0, misaligned=0.
- SW 0x10 data 0xDEADBEEF -> stall 1 cycle, then mem_we=1, mem_addr=0x10, mem_din=0xDEADBEEF. Then LW 0x10 -> resp_valid on 2nd cycle, resp_rdata=0xDEADBEEF.
- SB 0x13 data 0x000000A5 over 0xDEADBEEF -> stall 2 cycles, write 0xA5ADBEEF. Then LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5.
- Word 0x11228001 at 0x20:
  - SH 0x22 data 0x1234 -> writes 0x12348001.
  - LHU 0x22 -> 0x00001234.
  - LH 0x20 -> 0xFFFF8001.
- LW 0x11, then SH 0x21, then funct3=011 load -> each gives misaligned=1 for one cycle, mem_we never 1, resp_valid=0.
- SB in flight: assert rst during RMW_RD -> mem_we stays 0, target word unchanged, state IDLE after release.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller with sub-word extract/extend and read-modify-write over a word-only memory port
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misaligned,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_we,
    input  logic [31:0] mem_dout
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, FAULT} state_t;
    state_t state, state_n;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] wdata, merged, load_v;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        load_ok, store_ok, aligned, ok, accept;
    always_comb begin
        load_ok  = req_funct3[1:0] != 2'b11 && req_funct3 != 3'b110;
        store_ok = !req_funct3[2] && req_funct3[1:0] != 2'b11;
        aligned  = req_funct3[1:0] == 2'b01 ? !req_addr[0] :
                   req_funct3[1:0] == 2'b10 ? req_addr[1:0] == 2'b00 : 1'b1;
        ok       = (req_we ? store_ok : load_ok) && aligned;
        accept   = state == IDLE && req_valid && ok;
        state_n  = state == IDLE   ? (!req_valid ? IDLE : !ok ? FAULT : !req_we ? LOAD :
                                      req_funct3[1:0] == 2'b10 ? WRITE : RMW_RD) :
                   state == RMW_RD ? WRITE : IDLE;
        stall      = (state == IDLE && req_valid) || state == RMW_RD;
        resp_valid = state == LOAD;
        misaligned = state == FAULT;
    end
    // lane select and extension; unsigned variants have funct3[2] set
    always_comb begin
        byte_v = mem_dout[{off, 3'b000} +: 8];
        half_v = off[1] ? mem_dout[31:16] : mem_dout[15:0];
        load_v = f3[1:0] == 2'b00 ? {{24{byte_v[7] & ~f3[2]}}, byte_v} :
                 f3[1:0] == 2'b01 ? {{16{half_v[15] & ~f3[2]}}, half_v} : mem_dout;
        resp_rdata = resp_valid ? load_v : 32'd0;
        merged = mem_dout;
        if (f3[0])
            merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
        else
            merged[{off, 3'b000} +: 8] = wdata[7:0];
    end
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr <= '0;
            mem_din  <= '0;
            mem_we   <= 1'b0;
            f3       <= '0;
            off      <= '0;
            wdata    <= '0;
        end else if (accept) begin
            mem_addr <= {req_addr[31:2], 2'b00};
            f3       <= req_funct3;
            off      <= req_addr[1:0];
            wdata    <= req_wdata;
            mem_din  <= req_we && req_funct3[1:0] == 2'b10 ? req_wdata : mem_din;
            mem_we   <= req_we && req_funct3[1:0] == 2'b10;
        end else if (state == RMW_RD) begin
            mem_din <= merged;
            mem_we  <= 1'b1;
        end else if (state == WRITE) begin
            mem_we <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl against a word-addressed memory model
module tb_lsu_ctrl;
    logic        clk = 0, rst = 1, req_valid = 0, req_we = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        stall, resp_valid, misaligned, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;
    logic [31:0] mem [64];
    logic [31:0] exp_q [$];
    logic [31:0] e, caddr, cdin;
    logic        cwe, cmis, crv;
    int          tests = 0, fails = 0, we_cnt = 0, ns, w0;

    lsu_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .misaligned(misaligned), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_we(mem_we), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_din;
            we_cnt++;
        end
    end

    // scoreboard: every load response pops the oldest expected value
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL resp_unexpected got %h expected none", resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_rdata !== e) begin
                        fails++;
                        $display("FAIL resp_rdata got %h expected %h", resp_rdata, e);
                    end
                end
            end else if (resp_rdata !== 32'd0) begin
                fails++;
                $display("FAIL resp_rdata_idle got %h expected 0", resp_rdata);
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        ns = 0;
        #1;
        for (int i = 0; i < 10 && stall === 1'b1; i++) begin
            ns++;
            @(posedge clk); #1;
        end
        cwe = mem_we; caddr = mem_addr; cdin = mem_din; cmis = misaligned; crv = resp_valid;
        req_valid = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({mem_we, stall, resp_valid, misaligned} !== 4'b0 || mem_addr !== 0 || mem_din !== 0 || resp_rdata !== 0) begin
            fails++;
            $display("FAIL reset_init got we=%b st=%b rv=%b mis=%b addr=%h din=%h expected all 0", mem_we, stall, resp_valid, misaligned, mem_addr, mem_din);
        end
        @(negedge clk); rst = 0;
        issue(1, 3'b010, 32'h40, 32'h55);
        @(posedge clk); #2;
        rst = 1; #1;
        tests++;
        if ({mem_we, stall, resp_valid, misaligned} !== 4'b0 || mem_addr !== 0 || mem_din !== 0) begin
            fails++;
            $display("FAIL reset_idle got we=%b st=%b rv=%b mis=%b addr=%h din=%h expected all 0", mem_we, stall, resp_valid, misaligned, mem_addr, mem_din);
        end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_sw_lw();
        issue(1, 3'b010, 32'h10, 32'hDEADBEEF);
        tests++;
        if (ns !== 1 || cwe !== 1 || caddr !== 32'h10 || cdin !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL sw got stall=%0d we=%b addr=%h din=%h expected 1 1 00000010 deadbeef", ns, cwe, caddr, cdin);
        end
        exp_q.push_back(32'hDEADBEEF);
        issue(0, 3'b010, 32'h10, 0);
        tests++;
        if (ns !== 1 || crv !== 1 || cwe !== 0) begin
            fails++;
            $display("FAIL lw got stall=%0d rv=%b we=%b expected 1 1 0", ns, crv, cwe);
        end
    endtask

    task automatic test_sb();
        issue(1, 3'b000, 32'h13, 32'h000000A5);
        tests++;
        if (ns !== 2 || cwe !== 1 || caddr !== 32'h10 || cdin !== 32'hA5ADBEEF) begin
            fails++;
            $display("FAIL sb got stall=%0d we=%b addr=%h din=%h expected 2 1 00000010 a5adbeef", ns, cwe, caddr, cdin);
        end
        exp_q.push_back(32'hFFFFFFA5);
        issue(0, 3'b000, 32'h13, 0);
        exp_q.push_back(32'h000000A5);
        issue(0, 3'b100, 32'h13, 0);
        tests++;
        if (ns !== 1 || crv !== 1) begin
            fails++;
            $display("FAIL lbu got stall=%0d rv=%b expected 1 1", ns, crv);
        end
    endtask

    task automatic test_sh();
        issue(1, 3'b010, 32'h20, 32'h11228001);
        issue(1, 3'b001, 32'h22, 32'h00001234);
        tests++;
        if (ns !== 2 || cwe !== 1 || caddr !== 32'h20 || cdin !== 32'h12348001) begin
            fails++;
            $display("FAIL sh got stall=%0d we=%b addr=%h din=%h expected 2 1 00000020 12348001", ns, cwe, caddr, cdin);
        end
        exp_q.push_back(32'h00001234);
        issue(0, 3'b101, 32'h22, 0);
        exp_q.push_back(32'hFFFF8001);
        issue(0, 3'b001, 32'h20, 0);
        exp_q.push_back(32'hFFFFFF80);
        issue(0, 3'b000, 32'h21, 0);
        exp_q.push_back(32'h00000034);
        issue(0, 3'b000, 32'h22, 0);
    endtask

    task automatic test_faults();
        logic [35:0] tbl [3];
        tbl[0] = {1'b0, 3'b010, 32'h11};
        tbl[1] = {1'b1, 3'b001, 32'h21};
        tbl[2] = {1'b0, 3'b011, 32'h10};
        for (int k = 0; k < 3; k++) begin
            w0 = we_cnt;
            issue(tbl[k][35], tbl[k][34:32], tbl[k][31:0], 32'hFFFFFFFF);
            tests++;
            if (ns !== 1 || cmis !== 1 || crv !== 0 || cwe !== 0) begin
                fails++;
                $display("FAIL fault%0d got stall=%0d mis=%b rv=%b we=%b expected 1 1 0 0", k, ns, cmis, crv, cwe);
            end
            @(posedge clk); #1;
            tests++;
            if (misaligned !== 0 || we_cnt !== w0) begin
                fails++;
                $display("FAIL fault%0d_after got mis=%b writes=%0d expected 0 0", k, misaligned, we_cnt - w0);
            end
        end
        exp_q.push_back(32'h12348001);
        issue(0, 3'b010, 32'h20, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] b [4];
        b[0] = 32'hEF; b[1] = 32'hBE; b[2] = 32'hAD; b[3] = 32'hA5;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(b[k]);
            issue(0, 3'b100, 32'h10 + k, 0);
            tests++;
            if (ns !== 1) begin
                fails++;
                $display("FAIL b2b%0d got stall=%0d expected 1", k, ns);
            end
        end
    endtask

    task automatic test_rst_rmw();
        issue(1, 3'b010, 32'h30, 32'h11223344);
        @(posedge clk); #1;
        req_valid = 1; req_we = 1; req_funct3 = 3'b000; req_addr = 32'h31; req_wdata = 32'hFF;
        @(posedge clk); #1;
        w0 = we_cnt;
        rst = 1; #1;
        req_valid = 0;
        tests++;
        if (mem_we !== 0) begin
            fails++;
            $display("FAIL rmw_rst_we got %b expected 0", mem_we);
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (we_cnt !== w0 || mem[12] !== 32'h11223344) begin
            fails++;
            $display("FAIL rmw_rst_mem got writes=%0d word=%h expected 0 11223344", we_cnt - w0, mem[12]);
        end
        @(negedge clk); rst = 0;
        exp_q.push_back(32'h11223344);
        issue(0, 3'b010, 32'h30, 0);
        tests++;
        if (ns !== 1 || crv !== 1) begin
            fails++;
            $display("FAIL rmw_rst_idle got stall=%0d rv=%b expected 1 1", ns, crv);
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_sb();
        test_sh();
        test_faults();
        test_back_to_back();
        test_rst_rmw();
        repeat (2) @(posedge clk);
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
